// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_pkg : shared command codes, frame format and scheduler states  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package i2c_pkg;

  // Byte-engine command encodings
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;

  // Frame format: {addr[6:0], rw} header, length byte N, then N data bytes
  localparam int unsigned FRAME_BYTE_W   = 8;
  localparam int unsigned HDR_ADDR_W     = 7;
  localparam logic        HDR_RW_WRITE   = 1'b0;
  localparam int unsigned FRAME_OVERHEAD = 2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_HDR  = 4'd1,
    GET_LEN  = 4'd2,
    START    = 4'd3,
    ADDR     = 4'd4,
    GET_DATA = 4'd5,
    DATA     = 4'd6,
    STOP     = 4'd7,
    FLUSH    = 4'd8
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_tx_sched : pops framed writes from the byte FIFO and sequences |
// |                START/ADDR/DATA/STOP on the I2C byte engine.        |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module i2c_tx_sched
  import i2c_pkg::*;
#(
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         fifo_empty,
  input  logic [D-1:0] fifo_rdata,
  output logic         fifo_rd,
  output logic         cmd_valid,
  output logic [1:0]   cmd,
  output logic [7:0]   cmd_data,
  input  logic         cmd_ready,
  input  logic         cmd_done,
  input  logic         cmd_nack,
  output logic         busy,
  output logic         frame_done,
  output logic         frame_nack
);

  sched_state_t            r_state, w_state;
  logic [FRAME_BYTE_W-1:0] r_hdr, w_hdr;
  logic [FRAME_BYTE_W-1:0] r_cnt, w_cnt;
  logic                    r_abort, w_abort;
  logic                    r_sent, w_sent;
  logic                    r_fifo_rd, w_fifo_rd;
  logic                    r_cmd_valid, w_cmd_valid;
  logic [1:0]              r_cmd, w_cmd;
  logic [7:0]              r_cmd_data, w_cmd_data;
  logic                    r_busy, w_busy;
  logic                    r_frame_done, w_frame_done;
  logic                    r_frame_nack, w_frame_nack;

  logic                    w_pop_ok;
  logic                    w_cmd_acc;
  logic                    w_cmd_fin;
  logic [7:0]              w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hdr        <= '0;
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_sent       <= 1'b0;
      r_fifo_rd    <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= 2'b00;
      r_cmd_data   <= 8'h00;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_nack <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hdr        <= w_hdr;
      r_cnt        <= w_cnt;
      r_abort      <= w_abort;
      r_sent       <= w_sent;
      r_fifo_rd    <= w_fifo_rd;
      r_cmd_valid  <= w_cmd_valid;
      r_cmd        <= w_cmd;
      r_cmd_data   <= w_cmd_data;
      r_busy       <= w_busy;
      r_frame_done <= w_frame_done;
      r_frame_nack <= w_frame_nack;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_hdr        = r_hdr;
    w_cnt        = r_cnt;
    w_abort      = r_abort;
    w_sent       = r_sent;
    w_fifo_rd    = 1'b0;
    w_cmd_valid  = r_cmd_valid;
    w_cmd        = r_cmd;
    w_cmd_data   = r_cmd_data;
    w_frame_done = 1'b0;
    w_frame_nack = 1'b0;

    // A pop in flight leaves the FIFO head stale for one cycle, hence the gap
    w_pop_ok  = !fifo_empty && !r_fifo_rd;
    w_head    = fifo_rdata[7:0];
    w_cmd_acc = r_cmd_valid && cmd_ready;
    w_cmd_fin = !r_cmd_valid && r_sent && cmd_done;

    if (w_cmd_acc) begin
      w_cmd_valid = 1'b0;
      w_sent      = 1'b1;
    end

    // Every transition into a send state offers its command on the same edge
    case (r_state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          w_state = GET_HDR;
        end
      end
      GET_HDR: begin
        if (w_pop_ok) begin
          w_hdr     = w_head;
          w_fifo_rd = 1'b1;
          w_state   = GET_LEN;
        end
      end
      GET_LEN: begin
        if (w_pop_ok) begin
          w_cnt       = w_head;
          w_fifo_rd   = 1'b1;
          w_state     = START;
          w_cmd_valid = 1'b1;
          w_sent      = 1'b0;
          w_cmd       = CMD_START;
          w_cmd_data  = 8'h00;
        end
      end
      START: begin
        if (w_cmd_fin) begin
          w_state     = ADDR;
          w_cmd_valid = 1'b1;
          w_sent      = 1'b0;
          w_cmd       = CMD_WRITE;
          w_cmd_data  = r_hdr;
        end
      end
      ADDR: begin
        if (w_cmd_fin) begin
          if (cmd_nack || (r_cnt == 8'd0)) begin
            w_abort     = cmd_nack;
            w_state     = STOP;
            w_cmd_valid = 1'b1;
            w_sent      = 1'b0;
            w_cmd       = CMD_STOP;
            w_cmd_data  = 8'h00;
          end else begin
            w_state = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (w_pop_ok) begin
          w_fifo_rd   = 1'b1;
          w_state     = DATA;
          w_cmd_valid = 1'b1;
          w_sent      = 1'b0;
          w_cmd       = CMD_WRITE;
          w_cmd_data  = w_head;
        end
      end
      DATA: begin
        if (w_cmd_fin) begin
          w_cnt = r_cnt - 8'd1;
          if (cmd_nack || (r_cnt == 8'd1)) begin
            w_abort     = cmd_nack;
            w_state     = STOP;
            w_cmd_valid = 1'b1;
            w_sent      = 1'b0;
            w_cmd       = CMD_STOP;
            w_cmd_data  = 8'h00;
          end else begin
            w_state = GET_DATA;
          end
        end
      end
      STOP: begin
        if (w_cmd_fin) begin
          w_frame_done = 1'b1;
          w_frame_nack = r_abort;
          w_abort      = 1'b0;
          // Residual bytes of an aborted frame must leave the FIFO frame-aligned
          w_state      = (r_abort && (r_cnt != 8'd0)) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        if (r_cnt == 8'd0) begin
          w_state = IDLE;
        end else if (w_pop_ok) begin
          w_fifo_rd = 1'b1;
          w_cnt     = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    w_busy = (w_state != IDLE);
  end

  assign fifo_rd    = r_fifo_rd;
  assign cmd_valid  = r_cmd_valid;
  assign cmd        = r_cmd;
  assign cmd_data   = r_cmd_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign frame_nack = r_frame_nack;

endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2c_tx_sched : scoreboard bench with FIFO and byte-engine models |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_i2c_tx_sched;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_done;
  logic       cmd_nack;
  logic       busy;
  logic       frame_done;
  logic       frame_nack;

  always #5 clk = ~clk;

  i2c_tx_sched #(.D(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .cmd_done   (cmd_done),
    .cmd_nack   (cmd_nack),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_nack (frame_nack)
  );

  typedef struct {
    logic [1:0] c;
    logic [7:0] d;
    logic       nack;
  } exp_cmd_t;

  exp_cmd_t   exp_q[$];
  logic       exp_frm[$];
  logic [7:0] feed_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] fbytes[$];

  int n_vec = 0;
  int n_mis = 0;
  int pops = 0;
  int exp_pops = 0;
  int wr_acc = 0;
  int feed_pct = 100;
  int stall_max = 0;
  int force_stall = 0;

  // engine-model state
  logic     outstanding = 1'b0;
  logic     offer_seen = 1'b0;
  logic     out_nack = 1'b0;
  logic     held = 1'b0;
  logic [9:0] held_v = '0;
  int       stall = 0;
  int       done_cnt = 0;
  logic     prev_rd = 1'b0;
  exp_cmd_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void push_exp(input logic [1:0] c, input logic [7:0] d, input logic nk);
    exp_cmd_t e;
    e.c = c;
    e.d = d;
    e.nack = nk;
    exp_q.push_back(e);
  endfunction

  // Reference model: the command stream, pop count and frame outcome of one frame
  task automatic expect_frame(input logic [7:0] hdr, input int pos);
    int n;
    n = fbytes.size();
    push_exp(CMD_START, 8'h00, 1'b0);
    push_exp(CMD_WRITE, hdr, pos == 0);
    if (pos != 0) begin
      for (int i = 1; i <= n; i++) begin
        push_exp(CMD_WRITE, fbytes[i-1], i == pos);
        if (i == pos) break;
      end
    end
    push_exp(CMD_STOP, 8'h00, 1'b0);
    exp_frm.push_back(pos >= 0);
    exp_pops += FRAME_OVERHEAD + n;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int pos);
    feed_q.push_back(hdr);
    feed_q.push_back(8'(fbytes.size()));
    foreach (fbytes[i]) feed_q.push_back(fbytes[i]);
    expect_frame(hdr, pos);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_frm.size() != 0 || feed_q.size() != 0 ||
            fifo_q.size() != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_in_time"}, 32'(t < budget), 32'd1);
    check({name, "_pops"}, pops, exp_pops);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_fifo_rd"}, fifo_rd, 0);
    check({name, "_cmd_valid"}, cmd_valid, 0);
    check({name, "_cmd"}, cmd, 0);
    check({name, "_cmd_data"}, cmd_data, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_frame_done"}, frame_done, 0);
    check({name, "_frame_nack"}, frame_nack, 0);
  endtask

  // FIFO model: the pop strobe is acted on mid-cycle, before the next sampling edge
  initial begin
    fifo_empty = 1'b1;
    fifo_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        fifo_q.delete();
        prev_rd = 1'b0;
      end else begin
        if (fifo_rd) begin
          check("pop_gap", prev_rd, 0);
          check("pop_nonempty", 32'(fifo_q.size() != 0), 1);
          if (fifo_q.size() != 0) void'(fifo_q.pop_front());
          pops++;
        end
        if (feed_q.size() != 0 && $urandom_range(99, 0) < feed_pct)
          fifo_q.push_back(feed_q.pop_front());
        prev_rd = fifo_rd;
      end
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Engine model and scoreboard monitor
  initial begin
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_nack  = 1'b0;
    forever begin
      @(negedge clk);
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (rst) begin
        outstanding = 1'b0;
        offer_seen  = 1'b0;
        held        = 1'b0;
        cmd_ready   = 1'b0;
      end else begin
        if (frame_done) begin
          if (exp_frm.size() == 0) check("frame_done_unexpected", 1, 0);
          else check("frame_nack", frame_nack, exp_frm.pop_front());
        end else if (frame_nack) begin
          check("frame_nack_alone", frame_nack, 0);
        end

        if (held) begin
          check("valid_hold", cmd_valid, 1);
          check("cmd_hold", {cmd, cmd_data}, held_v);
        end
        held = 1'b0;

        if (outstanding) begin
          check("no_offer_before_done", cmd_valid, 0);
          if (done_cnt == 0) begin
            cmd_done    = 1'b1;
            cmd_nack    = out_nack;
            outstanding = 1'b0;
          end else begin
            done_cnt--;
          end
        end else if ($urandom_range(19, 0) == 0) begin
          // stray completion: must be ignored outside an outstanding command
          cmd_done = 1'b1;
          cmd_nack = 1'($urandom_range(1, 0));
        end

        if (cmd_valid && !outstanding) begin
          if (!offer_seen) begin
            offer_seen = 1'b1;
            stall = (force_stall != 0) ? force_stall : int'($urandom_range(stall_max, 0));
          end
          if (stall > 0) begin
            cmd_ready = 1'b0;
            stall--;
            held   = 1'b1;
            held_v = {cmd, cmd_data};
          end else begin
            cmd_ready  = 1'b1;
            offer_seen = 1'b0;
            if (exp_q.size() == 0) begin
              check("cmd_unexpected", {cmd, cmd_data}, 10'h3ff);
              out_nack = 1'b0;
            end else begin
              mon_e = exp_q.pop_front();
              check("cmd_code", cmd, mon_e.c);
              check("cmd_data", cmd_data, mon_e.d);
              out_nack = mon_e.nack || ((mon_e.c != CMD_WRITE) && ($urandom_range(1, 0) == 1));
            end
            if (cmd == CMD_WRITE) wr_acc++;
            outstanding = 1'b1;
            done_cnt    = $urandom_range(2, 0);
          end
        end else begin
          cmd_ready = 1'($urandom_range(1, 0));
        end
      end
    end
  end

  initial begin
    int base;
    int t;
    int n;
    int pos;
    logic [7:0] hdr;

    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;

    // plain write, engine always ready
    fbytes.delete();
    fbytes.push_back(8'h11);
    fbytes.push_back(8'h22);
    send_frame(8'hA0, -1);
    wait_idle("write2", 300);

    // address-only probe
    fbytes.delete();
    send_frame(8'h90, -1);
    wait_idle("probe", 300);

    // NACK on address, then a good frame behind it
    stall_max = 2;
    fbytes.delete();
    fbytes.push_back(8'h01);
    fbytes.push_back(8'h02);
    fbytes.push_back(8'h03);
    send_frame(8'hA0, 0);
    fbytes.delete();
    fbytes.push_back(8'h55);
    send_frame(8'hB0, -1);
    wait_idle("addr_nack", 500);

    // NACK on the last data byte: nothing left to flush
    fbytes.delete();
    fbytes.push_back(8'h7E);
    fbytes.push_back(8'h7F);
    send_frame(8'hC2, 2);
    wait_idle("last_nack", 500);

    // engine stalls every offer for 5 cycles
    force_stall = 5;
    fbytes.delete();
    fbytes.push_back(8'h33);
    send_frame(8'hD4, -1);
    wait_idle("stall", 500);
    force_stall = 0;

    // header only, length byte arrives later
    feed_q.push_back(8'hC4);
    repeat (20) @(negedge clk);
    check("hdr_only_busy", busy, 1);
    check("hdr_only_no_cmd", cmd_valid, 0);
    fbytes.delete();
    fbytes.push_back(8'hE1);
    fbytes.push_back(8'hE2);
    feed_q.push_back(8'h02);
    feed_q.push_back(8'hE1);
    feed_q.push_back(8'hE2);
    expect_frame(8'hC4, -1);
    wait_idle("hdr_only", 500);

    // enable low holds the scheduler in IDLE
    enable = 1'b0;
    fbytes.delete();
    fbytes.push_back(8'h44);
    base = pops;
    send_frame(8'hA6, -1);
    repeat (10) @(negedge clk);
    check("disabled_idle", busy, 0);
    check("disabled_no_pop", pops, base);
    enable = 1'b1;
    wait_idle("enable", 500);

    // reset while the 2nd of 3 data bytes is on the bus
    stall_max = 0;
    fbytes.delete();
    fbytes.push_back(8'h0A);
    fbytes.push_back(8'h0B);
    fbytes.push_back(8'h0C);
    base = wr_acc;
    send_frame(8'hA2, -1);
    t = 0;
    while (wr_acc < base + 3 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rst_reached_data", 32'(t < 300), 1);
    #1;
    rst = 1'b1;
    feed_q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    #1;
    exp_q.delete();
    exp_frm.delete();
    feed_q.delete();
    pops     = 0;
    exp_pops = 0;
    rst      = 1'b0;
    fbytes.delete();
    fbytes.push_back(8'h5A);
    send_frame(8'h80, -1);
    wait_idle("after_rst", 500);

    // randomized frames, NACKs, stalls and FIFO starvation
    stall_max = 3;
    feed_pct  = 60;
    for (int f = 0; f < 40; f++) begin
      t = 0;
      while (exp_frm.size() > 2 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      n = $urandom_range(6, 0);
      fbytes.delete();
      for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom_range(255, 0)));
      pos = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n, 0)) : -1;
      hdr = {7'($urandom_range(127, 0)), HDR_RW_WRITE};
      send_frame(hdr, pos);
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(8, 1)) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
      end
    end
    wait_idle("random", 20000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_tx_sched.md
# i2c_tx_sched

Frame scheduler between the byte FIFO and the I2C byte engine. It pops framed write transactions from the FIFO: a header byte `{addr[6:0], 1'b0}`, a length byte N, then N data bytes. It issues START, ADDR, DATA×N and STOP commands to the engine over a valid/ready handshake. On NACK it aborts the bus transaction and flushes the rest of the frame so the FIFO stays frame-aligned.

## Interface
- `D`, 8: FIFO data width; only bits [7:0] are used.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset. The same signal drives the FIFO's `rst`.
- `enable` in 1: permits starting a new frame.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rdata` in D: FIFO head word, combinational from the FIFO.
- `fifo_rd` out 1: pop strobe to the FIFO's edge-triggered `rd`.
- `cmd_valid` out 1: command offered to the byte engine.
- `cmd` out 2: command code: START=2'b00, WRITE=2'b01, STOP=2'b10.
- `cmd_data` out 8: byte for WRITE, 0 otherwise.
- `cmd_ready` in 1: engine accepts the command this cycle.
- `cmd_done` in 1: one-cycle pulse when the accepted command completes on the bus.
- `cmd_nack` in 1: sampled only with `cmd_done`; 1 means the slave NACKed the WRITE.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after STOP completes.
- `frame_nack` out 1: one-cycle pulse, coincident with `frame_done`, if the frame was aborted.

## Operation
- States: IDLE, GET_HDR, GET_LEN, START, ADDR, GET_DATA, DATA, STOP, FLUSH.
- Pop rule (GET_*, FLUSH): if `!fifo_empty` and the pop gap is clear, latch `fifo_rdata[7:0]` and assert `fifo_rd` for exactly one cycle in the same cycle.
- Pop gap: after any pop, `fifo_rd` stays low for at least 1 cycle, so the peak rate is 1 pop per 2 cycles. If `fifo_empty`, wait with no pop.
- IDLE → GET_HDR when `enable && !fifo_empty`.
- GET_HDR: latch `hdr`, then go to GET_LEN.
- GET_LEN: latch `cnt` (8-bit) = N, then go to START.
- START, ADDR, DATA, STOP (send states):
  - Hold `cmd_valid=1` with `cmd`/`cmd_data` stable until `cmd_ready`.
  - Drop `cmd_valid` the cycle after acceptance, then wait for `cmd_done`.
  - Never offer a new command before the previous `cmd_done`.
- START done → ADDR, with WRITE of `hdr`.
- ADDR done:
  - `cmd_nack` → set the abort flag and go to STOP.
  - Else if `cnt==0` → STOP (address-only probe).
  - Else → GET_DATA.
- GET_DATA: pop one byte, then go to DATA.
- DATA done: decrement `cnt`.
  - `cmd_nack` → set abort and go to STOP.
  - Else if `cnt` (after decrement) ==0 → STOP.
  - Else → GET_DATA.
- STOP done:
  - Pulse `frame_done` (and `frame_nack` if abort is set).
  - If abort is set and `cnt!=0` → FLUSH; else → IDLE.
- FLUSH: pop and discard `cnt` bytes, decrementing per pop. At `cnt==0` → IDLE. No engine commands are issued.
- `enable` is checked only in IDLE; dropping it mid-frame does not abort the frame.
- NACK on the last DATA byte: `cnt` is already 0, so no FLUSH.
- NACK on ADDR with N=5: all 5 data bytes are flushed.

## Timing
- Reset values: `fifo_rd=0`, `cmd_valid=0`, `cmd=0`, `cmd_data=0`, `busy=0`, `frame_done=0`, `frame_nack=0`, state=IDLE, `cnt=0`, abort=0.
- All outputs are registered.
- `fifo_rd` is never high on two consecutive cycles.
- IDLE with a non-empty FIFO → first `cmd_valid`: 4 cycles (pop, gap, pop, gap).
- `cmd_ready` combinationally high at offer: command accepted the same cycle.
- `cmd_done` is ignored while `cmd_valid=1`. A `cmd_done` in IDLE/GET_*/FLUSH is ignored.
- `rst` mid-frame: next cycle everything is at reset values and no STOP is issued. FIFO and engine reset on the same edge.

## Structure
- Shared `i2c_pkg` holds: command encodings `CMD_START/CMD_WRITE/CMD_STOP`, the state enum, and the header/length frame-format constants.
- Single flat FSM module with no sub-modules. The FIFO and the byte engine are instantiated by the parent.

## Test plan
- Frame `{0xA0, 0x02, 0x11, 0x22}`, engine always ready, no NACK → commands START, W 0xA0, W 0x11, W 0x22, STOP; 4 `fifo_rd` pulses; one `frame_done`, `frame_nack=0`.
- Frame `{0x90, 0x00}` → START, W 0x90, STOP; 2 pops.
- Frame `{0xA0, 0x03, 1, 2, 3}` then `{0xB0, 0x01, 0x55}`, NACK on ADDR → STOP, 3 bytes flushed with no commands, `frame_nack` pulse; next frame sends START, W 0xB0, W 0x55, STOP.
- `cmd_ready` held low 5 cycles → `cmd_valid`, `cmd`, `cmd_data` stay stable for all 5 cycles; no extra pops.
- FIFO holds only the header and empties mid-frame → waits in GET_LEN with `busy=1`; resumes when the length byte arrives; `fifo_rd` never on consecutive cycles.
- `rst` asserted while in DATA with `cnt=2` → next cycle all outputs 0 and state IDLE; a fresh frame then runs normally.
